// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared MIPS encodings for the multi-cycle controller: opcode/funct constants,
// FSM state codes, ALU operation enum and datapath mux select values.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J     = 6'h02, OP_JAL   = 6'h03,
                         OP_BEQ   = 6'h04, OP_BNE   = 6'h05, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI  = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ORI   = 6'h0d, OP_XORI  = 6'h0e, OP_LUI   = 6'h0f,
                         OP_LW    = 6'h23, OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA  = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV = 6'h07,
                         FN_JR   = 6'h08, FN_ADD  = 6'h20, FN_ADDU = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND  = 6'h24,
                         FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR  = 6'h27,
                         FN_SLT  = 6'h2a, FN_SLTU = 6'h2b;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV, ALU_LUI
  } alu_op_e;

  localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_EXEC_R = 4'd2,
                         ST_EXEC_I = 4'd3, ST_MEM_ADDR = 4'd4, ST_MEM_RD = 4'd5,
                         ST_MEM_WR = 4'd6, ST_WB_ALU = 4'd7,  ST_WB_MEM = 4'd8,
                         ST_BRANCH = 4'd9, ST_JUMP = 4'd10,   ST_JR = 4'd11,
                         ST_ILLEGAL = 4'd12;

  localparam logic [1:0] PC_SRC_ALU = 2'd0, PC_SRC_ALUOUT = 2'd1, PC_SRC_JUMP = 2'd2, PC_SRC_RS = 2'd3;
  localparam logic [1:0] SRC_A_PC = 2'd0, SRC_A_RS = 2'd1, SRC_A_SHAMT = 2'd2;
  localparam logic [1:0] SRC_B_RT = 2'd0, SRC_B_FOUR = 2'd1, SRC_B_IMM = 2'd2, SRC_B_IMM_SH2 = 2'd3;
  localparam logic [1:0] REG_DST_RT = 2'd0, REG_DST_RD = 2'd1, REG_DST_RA = 2'd2;
  localparam logic [1:0] M2R_ALUOUT = 2'd0, M2R_MDR = 2'd1, M2R_PC = 2'd2;

  function automatic logic is_shamt_shift(input logic [5:0] funct);
    return (funct == FN_SLL) || (funct == FN_SRL) || (funct == FN_SRA);
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// Combinational (opcode, funct) -> ALU operation, immediate extension mode and
// a legal flag for encodings the multi-cycle datapath supports.
module mips_alu_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       ext_sign,
  output logic       legal
);

  always_comb begin
    alu_op   = ALU_ADD;
    ext_sign = 1'b1;
    legal    = 1'b1;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_SLL:          alu_op = ALU_SLL;
          FN_SRL:          alu_op = ALU_SRL;
          FN_SRA:          alu_op = ALU_SRA;
          FN_SLLV:         alu_op = ALU_SLLV;
          FN_SRLV:         alu_op = ALU_SRLV;
          FN_SRAV:         alu_op = ALU_SRAV;
          FN_JR:           alu_op = ALU_ADD;
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_XOR:          alu_op = ALU_XOR;
          FN_NOR:          alu_op = ALU_NOR;
          FN_SLT:          alu_op = ALU_SLT;
          FN_SLTU:         alu_op = ALU_SLTU;
          default:         legal  = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW, OP_J, OP_JAL: alu_op = ALU_ADD;
      OP_SLTI:       alu_op = ALU_SLT;
      OP_SLTIU:      alu_op = ALU_SLTU;
      OP_BEQ, OP_BNE: alu_op = ALU_SUB;
      // Logical immediates and LUI take the immediate zero-extended.
      OP_ORI:  begin alu_op = ALU_OR;  ext_sign = 1'b0; end
      OP_XORI: begin alu_op = ALU_XOR; ext_sign = 1'b0; end
      OP_LUI:  begin alu_op = ALU_LUI; ext_sign = 1'b0; end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore control FSM for the multi-cycle MIPS datapath; 3-5 cycles per instruction plus memory waits.
// Stalls in FETCH/MEM_RD/MEM_WR until mem_ready; MC_CTRL_ILLEGAL_EN traps unknown encodings in ILLEGAL.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        ext_sign,
  output logic [3:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  reg_dst,
  output logic [1:0]  mem_to_reg,
  output logic        illegal
);

  logic [3:0] state_q, state_d;
  logic [5:0] opcode, funct;
  alu_op_e    dec_alu_op;
  logic       dec_ext_sign, dec_legal;
  logic       unused_instr_bits;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign unused_instr_bits = ^instr[25:6];

  mips_alu_decode u_alu_decode (
    .opcode   (opcode),
    .funct    (funct),
    .alu_op   (dec_alu_op),
    .ext_sign (dec_ext_sign),
    .legal    (dec_legal)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        state_d = ST_FETCH;
        if (!dec_legal) begin
`ifdef MC_CTRL_ILLEGAL_EN
          state_d = ST_ILLEGAL;
`endif
        end else begin
          case (opcode)
            OP_RTYPE: state_d = (funct == FN_JR) ? ST_JR : ST_EXEC_R;
            OP_LW, OP_SW:    state_d = ST_MEM_ADDR;
            OP_BEQ, OP_BNE:  state_d = ST_BRANCH;
            OP_J, OP_JAL:    state_d = ST_JUMP;
            default:         state_d = ST_EXEC_I;
          endcase
        end
      end
      ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
      ST_MEM_ADDR: state_d = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   if (mem_ready) state_d = ST_WB_MEM;
      ST_MEM_WR:   if (mem_ready) state_d = ST_FETCH;
`ifdef MC_CTRL_ILLEGAL_EN
      ST_ILLEGAL:  state_d = ST_ILLEGAL;
`endif
      default:     state_d = ST_FETCH;
    endcase
    if (rst) state_d = ST_FETCH;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Reset overrides the decode so an abandoned instruction never writes anything.
  always_comb begin
    mem_req = 1'b0; mem_we = 1'b0; iord = 1'b0; ir_we = 1'b0; pc_we = 1'b0;
    pc_src = PC_SRC_ALU; alu_src_a = SRC_A_PC; alu_src_b = SRC_B_RT;
    ext_sign = 1'b0; alu_op = ALU_ADD; reg_we = 1'b0; reg_dst = REG_DST_RT;
    mem_to_reg = M2R_ALUOUT; illegal = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1; alu_src_b = SRC_B_FOUR;
          ir_we = mem_ready; pc_we = mem_ready;
        end
        ST_DECODE: begin
          alu_src_b = SRC_B_IMM_SH2; ext_sign = 1'b1;
        end
        ST_EXEC_R: begin
          alu_src_a = is_shamt_shift(funct) ? SRC_A_SHAMT : SRC_A_RS;
          alu_op = dec_alu_op;
        end
        ST_EXEC_I: begin
          alu_src_a = SRC_A_RS; alu_src_b = SRC_B_IMM;
          ext_sign = dec_ext_sign; alu_op = dec_alu_op;
        end
        ST_MEM_ADDR: begin
          alu_src_a = SRC_A_RS; alu_src_b = SRC_B_IMM; ext_sign = 1'b1;
        end
        ST_MEM_RD: begin mem_req = 1'b1; iord = 1'b1; end
        ST_MEM_WR: begin mem_req = 1'b1; mem_we = 1'b1; iord = 1'b1; end
        ST_WB_ALU: begin
          reg_we = 1'b1;
          reg_dst = (opcode == OP_RTYPE) ? REG_DST_RD : REG_DST_RT;
        end
        ST_WB_MEM: begin reg_we = 1'b1; mem_to_reg = M2R_MDR; end
        ST_BRANCH: begin
          alu_src_a = SRC_A_RS; alu_op = ALU_SUB; pc_src = PC_SRC_ALUOUT;
          pc_we = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
        end
        ST_JUMP: begin
          pc_we = 1'b1; pc_src = PC_SRC_JUMP;
          if (opcode == OP_JAL) begin
            reg_we = 1'b1; reg_dst = REG_DST_RA; mem_to_reg = M2R_PC;
          end
        end
        ST_JR: begin pc_we = 1'b1; pc_src = PC_SRC_RS; end
`ifdef MC_CTRL_ILLEGAL_EN
        ST_ILLEGAL: illegal = 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl (default build, MC_CTRL_ILLEGAL_EN undefined).
module tb_mips_multicycle_ctrl;
  import mips_multicycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        alu_zero = 1'b0, mem_ready = 1'b0;
  logic        mem_req, mem_we, iord, ir_we, pc_we, ext_sign, reg_we, illegal;
  logic [1:0]  pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
  logic [3:0]  alu_op;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_sign(ext_sign),
    .alu_op(alu_op), .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src, a, b;
    logic       ext;
    logic [3:0] op;
    logic       reg_we;
    logic [1:0] reg_dst, m2r;
    logic       illegal;
  } out_t;

  typedef struct {
    logic [31:0] ins;
    logic        z;
    int          cycles;
    out_t        last;
    string       name;
  } vec_t;

  out_t act;
  assign act = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                ext_sign, alu_op, reg_we, reg_dst, mem_to_reg, illegal};

  int checks = 0, errors = 0;

  localparam int C_R = 0, C_JR = 1, C_I = 2, C_LW = 3, C_SW = 4, C_BR = 5, C_J = 6, C_NOP = 7;

  function automatic out_t mk(logic mreq, logic mwe, logic io, logic irw, logic pcw,
                              logic [1:0] pcs, logic [1:0] a, logic [1:0] b, logic ext,
                              logic [3:0] op, logic rw, logic [1:0] rd, logic [1:0] m2r);
    out_t o;
    o = {mreq, mwe, io, irw, pcw, pcs, a, b, ext, op, rw, rd, m2r, 1'b0};
    return o;
  endfunction

  // Reference ALU op for R-type funct codes; 4'hf marks an unsupported funct.
  function automatic logic [3:0] r_alu(logic [5:0] fn);
    case (fn)
      6'h00: return ALU_SLL;   6'h02: return ALU_SRL;   6'h03: return ALU_SRA;
      6'h04: return ALU_SLLV;  6'h06: return ALU_SRLV;  6'h07: return ALU_SRAV;
      6'h20, 6'h21: return ALU_ADD;  6'h22, 6'h23: return ALU_SUB;
      6'h24: return ALU_AND;   6'h25: return ALU_OR;    6'h26: return ALU_XOR;
      6'h27: return ALU_NOR;   6'h2a: return ALU_SLT;   6'h2b: return ALU_SLTU;
      default: return 4'hf;
    endcase
  endfunction

  function automatic int classify(logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26]; fn = ins[5:0];
    if (op == 6'h00) return (fn == 6'h08) ? C_JR : ((r_alu(fn) != 4'hf) ? C_R : C_NOP);
    case (op)
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0d, 6'h0e, 6'h0f: return C_I;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02, 6'h03: return C_J;
      default: return C_NOP;
    endcase
  endfunction

  function automatic int n_steps(logic [31:0] ins);
    case (classify(ins))
      C_LW: return 5;
      C_R, C_I, C_SW: return 4;
      C_NOP: return 2;
      default: return 3;
    endcase
  endfunction

  function automatic bit is_mem_step(logic [31:0] ins, int step);
    int c;
    c = classify(ins);
    return (step == 0) || (step == 3 && (c == C_LW || c == C_SW));
  endfunction

  // Expected outputs for the given step of an instruction, derived from its class.
  function automatic out_t exp_out(logic [31:0] ins, logic z, int step, logic rdy);
    out_t o;
    logic [5:0] op, fn;
    int c;
    o = '0; op = ins[31:26]; fn = ins[5:0]; c = classify(ins);
    if (step == 0) begin
      o.mem_req = 1; o.b = 2'd1; o.ir_we = rdy; o.pc_we = rdy;
    end else if (step == 1) begin
      o.b = 2'd3; o.ext = 1;
    end else begin
      case (c)
        C_R: if (step == 2) begin
               o.a = (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) ? 2'd2 : 2'd1;
               o.b = 2'd0; o.op = r_alu(fn);
             end else begin o.reg_we = 1; o.reg_dst = 2'd1; end
        C_I: if (step == 2) begin
               o.a = 2'd1; o.b = 2'd2;
               o.ext = !(op == 6'h0d || op == 6'h0e || op == 6'h0f);
               case (op)
                 6'h0a: o.op = ALU_SLT;  6'h0b: o.op = ALU_SLTU;
                 6'h0d: o.op = ALU_OR;   6'h0e: o.op = ALU_XOR;
                 6'h0f: o.op = ALU_LUI;  default: o.op = ALU_ADD;
               endcase
             end else o.reg_we = 1;
        C_LW, C_SW: begin
          if (step == 2) begin o.a = 2'd1; o.b = 2'd2; o.ext = 1; end
          else if (step == 3) begin o.mem_req = 1; o.iord = 1; o.mem_we = (c == C_SW); end
          else begin o.reg_we = 1; o.m2r = 2'd1; end
        end
        C_BR: begin
          o.a = 2'd1; o.op = ALU_SUB; o.pc_src = 2'd1;
          o.pc_we = (op == 6'h04) ? z : !z;
        end
        C_J: begin
          o.pc_we = 1; o.pc_src = 2'd2;
          if (op == 6'h03) begin o.reg_we = 1; o.reg_dst = 2'd2; o.m2r = 2'd2; end
        end
        C_JR: begin o.pc_we = 1; o.pc_src = 2'd3; end
        default: ;
      endcase
    end
    return o;
  endfunction

  task automatic check(input string nm, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s instr=%h: got %h want %h", nm, instr, got, want);
    end
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Starts and ends at posedge+1 of a FETCH cycle; checks every cycle against the model.
  task automatic run_instr(input logic [31:0] ins, input int stall_pct);
    int step, guard;
    step = 0; guard = 0;
    instr = ins;
    while (step < n_steps(ins) && guard < 100) begin
      mem_ready = ($urandom_range(0, 99) >= stall_pct);
      alu_zero  = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rand_cycle", act, exp_out(ins, alu_zero, step, mem_ready));
      if (!(is_mem_step(ins, step) && !mem_ready)) step++;
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 100) check_int("rand_timeout", guard, 0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    logic [5:0] fns [16];
    logic [5:0] iops [7];
    fns  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
             6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b};
    iops = '{6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0d, 6'h0e, 6'h0f};
    r = $urandom;
    case ($urandom_range(0, 9))
      0: return {6'h00, r[25:6], fns[$urandom_range(0, 15)]};
      1: return {6'h00, r[25:21], 15'h0, 6'h08};
      2: return {iops[$urandom_range(0, 6)], r[25:0]};
      3: return {6'h23, r[25:0]};
      4: return {6'h2b, r[25:0]};
      5: return {6'h04, r[25:0]};
      6: return {6'h05, r[25:0]};
      7: return {6'h02, r[25:0]};
      8: return {6'h03, r[25:0]};
      default: return r[0] ? {6'h3f, r[25:0]} : {6'h00, r[25:6], 6'h01};
    endcase
  endfunction

  out_t FETCH_RDY, FETCH_WAIT, DECODE_O, WB_I;
  vec_t vecs [13];
  int cnt;

  initial begin
    FETCH_RDY  = mk(1,0,0,1,1, 2'd0, 2'd0, 2'd1, 0, ALU_ADD, 0, 2'd0, 2'd0);
    FETCH_WAIT = mk(1,0,0,0,0, 2'd0, 2'd0, 2'd1, 0, ALU_ADD, 0, 2'd0, 2'd0);
    DECODE_O   = mk(0,0,0,0,0, 2'd0, 2'd0, 2'd3, 1, ALU_ADD, 0, 2'd0, 2'd0);
    WB_I       = mk(0,0,0,0,0, 2'd0, 2'd0, 2'd0, 0, ALU_ADD, 1, 2'd0, 2'd0);
    vecs[0]  = '{32'h24080005, 0, 4, WB_I, "addiu_wb"};
    vecs[1]  = '{32'h8C090004, 0, 5, mk(0,0,0,0,0, 0, 0, 0, 0, ALU_ADD, 1, 2'd0, 2'd1), "lw_wb"};
    vecs[2]  = '{32'hAC090008, 0, 4, mk(1,1,1,0,0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0), "sw_memwr"};
    vecs[3]  = '{32'h1109FFFF, 1, 3, mk(0,0,0,0,1, 2'd1, 2'd1, 2'd0, 0, ALU_SUB, 0, 0, 0), "beq_taken"};
    vecs[4]  = '{32'h1109FFFF, 0, 3, mk(0,0,0,0,0, 2'd1, 2'd1, 2'd0, 0, ALU_SUB, 0, 0, 0), "beq_not"};
    vecs[5]  = '{32'h15090002, 0, 3, mk(0,0,0,0,1, 2'd1, 2'd1, 2'd0, 0, ALU_SUB, 0, 0, 0), "bne_taken"};
    vecs[6]  = '{32'h0C000010, 0, 3, mk(0,0,0,0,1, 2'd2, 0, 0, 0, ALU_ADD, 1, 2'd2, 2'd2), "jal"};
    vecs[7]  = '{32'h08000010, 0, 3, mk(0,0,0,0,1, 2'd2, 0, 0, 0, ALU_ADD, 0, 0, 0), "j"};
    vecs[8]  = '{32'h03E00008, 0, 3, mk(0,0,0,0,1, 2'd3, 0, 0, 0, ALU_ADD, 0, 0, 0), "jr"};
    vecs[9]  = '{32'h01095020, 0, 4, mk(0,0,0,0,0, 0, 0, 0, 0, ALU_ADD, 1, 2'd1, 2'd0), "add_wb"};
    vecs[10] = '{32'h3508FFFF, 0, 4, WB_I, "ori_wb"};
    vecs[11] = '{32'hFC000000, 0, 2, DECODE_O, "unknown_op_nop"};
    vecs[12] = '{32'h00000001, 0, 2, DECODE_O, "unknown_funct_nop"};

    // Reset: every output is low regardless of inputs.
    instr = 32'h8C090004; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", act, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table: zero wait states; each entry's first cycle confirms the previous one retired on time.
    foreach (vecs[k]) begin
      instr = vecs[k].ins; alu_zero = vecs[k].z; mem_ready = 1'b1;
      for (int c = 1; c <= vecs[k].cycles; c++) begin
        @(negedge clk);
        if (c == 1) check("fetch_start", act, FETCH_RDY);
        if (c == vecs[k].cycles) check(vecs[k].name, act, vecs[k].last);
        @(posedge clk); #1;
      end
    end

    // lw with two wait cycles in MEM_RD: request held 3 cycles, WB_MEM on cycle 7.
    instr = 32'h8C090004; cnt = 0;
    for (int c = 1; c <= 7; c++) begin
      mem_ready = !(c == 4 || c == 5);
      @(negedge clk);
      if (c == 1) check("lw_stall_fetch", act, FETCH_RDY);
      if (mem_req && iord) cnt++;
      if (c == 7) check("lw_stall_wb", act, mk(0,0,0,0,0, 0, 0, 0, 0, ALU_ADD, 1, 2'd0, 2'd1));
      @(posedge clk); #1;
    end
    check_int("lw_memrd_cycles", cnt, 3);

    // Reset while a store is waiting in MEM_WR.
    instr = 32'hAC090008;
    for (int c = 1; c <= 4; c++) begin
      mem_ready = (c < 4);
      @(negedge clk);
      if (c == 4) check("sw_pending", act, mk(1,1,1,0,0, 0, 0, 0, 0, ALU_ADD, 0, 0, 0));
      @(posedge clk); #1;
    end
    mem_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_in_memwr", act, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_fetch", act, FETCH_WAIT);
    @(posedge clk); #1;

    // Unknown opcode 6'b111111: two-cycle NOP, no enables, then FETCH again.
    instr = 32'hFC001234; mem_ready = 1'b1;
    @(negedge clk); check("ill_fetch", act, FETCH_RDY);
    @(posedge clk); #1;
    @(negedge clk); check("ill_decode", act, DECODE_O);
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk); check("ill_back_fetch", act, FETCH_WAIT);
    @(posedge clk); #1;

    // Random instruction stream with memory stalls against the class-level model.
    for (int n = 0; n < 150; n++) run_instr(rand_instr(), 30);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style control FSM that sequences a shared-memory, multi-cycle MIPS datapath (PC, IR, register file, ALU, ALUOut/MDR registers). Decodes the instruction register using the team's MIPS opcode/function package, drives every datapath mux select and write enable each cycle, and stalls on a single-port memory request/ready handshake. Sits between the datapath top level and the unified instruction/data memory port.

## Interface
- No parameters; encodings come from the shared package.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  current IR contents
- alu_zero  in  1  ALU zero flag, combinational
- mem_ready  in  1  memory completes the request this cycle
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  write qualifier for mem_req
- iord  out  1  address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  PC write enable
- pc_src  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs
- alu_src_a  out  2  0 = PC, 1 = rs, 2 = zero-extended shamt
- alu_src_b  out  2  0 = rt, 1 = constant 4, 2 = extended imm, 3 = extended imm << 2
- ext_sign  out  1  1 = sign-extend imm, 0 = zero-extend
- alu_op  out  4  ALU operation code (package enum)
- reg_we  out  1  register-file write enable
- reg_dst  out  2  0 = rt, 1 = rd, 2 = $31
- mem_to_reg  out  2  0 = ALUOut, 1 = MDR, 2 = PC
- illegal  out  1  unsupported instruction trapped (see Configuration)

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, JR, ILLEGAL.
- FETCH: mem_req=1, iord=0, A=PC, B=4, ADD. On mem_ready: ir_we=1, pc_we=1, pc_src=0, go DECODE. Otherwise hold and keep all write enables low.
- DECODE: A=PC, B=imm<<2, sign-extend, ADD (branch target into ALUOut). Dispatch by opcode: RTYPE with funct JR -> JR; other funct -> EXEC_R; ADDI/ADDIU/ORI/XORI/LUI/SLTI/SLTIU -> EXEC_I; LW/SW -> MEM_ADDR; BEQ/BNE -> BRANCH; J/JAL -> JUMP; anything else -> ILLEGAL or FETCH (Configuration).
- EXEC_R: B=rt. A=shamt for SLL/SRL/SRA, else A=rs. Select alu_op from funct. Go WB_ALU.
- EXEC_I: A=rs, B=imm. ext_sign=0 for ORI/XORI/LUI, else 1. ADDI behaves as ADDIU; there is no overflow trap. Go WB_ALU.
- WB_ALU: reg_we=1, mem_to_reg=0. reg_dst=1 for R-type, 0 for I-type. Go FETCH.
- MEM_ADDR: A=rs, B=sign-extended imm, ADD. Go MEM_RD for LW, MEM_WR for SW.
- MEM_RD: mem_req=1, iord=1; hold until mem_ready, then go WB_MEM.
- WB_MEM: reg_we=1, reg_dst=0, mem_to_reg=1. Go FETCH.
- MEM_WR: mem_req=1, mem_we=1, iord=1; hold until mem_ready, then go FETCH.
- BRANCH: A=rs, B=rt, SUB. pc_src=1; pc_we=alu_zero for BEQ, ~alu_zero for BNE. Go FETCH.
- JUMP: pc_we=1, pc_src=2. JAL additionally drives reg_we=1, reg_dst=2, mem_to_reg=2 (PC already holds PC+4). Go FETCH.
- JR: pc_we=1, pc_src=3. Go FETCH.
- Unlisted outputs are 0 in every state.

## Timing
- State is registered; outputs decode combinationally from the state register and instr.
- Cycle counts with zero wait states: BEQ/BNE/J/JAL/JR = 3; R-type, I-type ALU and SW = 4; LW = 5. Each memory wait cycle adds 1.
- When mem_ready is already high on the first FETCH cycle, the fetch completes in that cycle.
- While rst=1: every output is forced to 0 and the state is loaded with FETCH. mem_req rises in the first cycle after rst falls.
- Reset mid-instruction, including a pending MEM_WR: the instruction is abandoned. No write enable is asserted during or after reset for that instruction.
- instr must be stable from DECODE until the instruction retires. IR is written only in FETCH.

## Configuration
- MC_CTRL_ILLEGAL_EN defined: an unknown opcode, or an unknown funct under RTYPE, goes to ILLEGAL. In ILLEGAL: illegal=1, all enables 0, mem_req=0. It stays there until rst.
- MC_CTRL_ILLEGAL_EN undefined: an unknown encoding returns from DECODE to FETCH and executes as a 2-cycle NOP. illegal is tied to 0.

## Structure
- Shared package: state enum, alu_op enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, LUI), and the pc_src/alu_src/reg_dst/mem_to_reg select constants. These sit alongside the opcode/funct constants.
- One sub-module: mips_alu_decode, combinational (opcode, funct) -> alu_op, ext_sign and a legal flag. It is shared with the datapath ALU tests.

## Test plan
- addiu $t0,$0,5 (0x24080005), mem_ready always 1 -> 4 cycles; in WB_ALU reg_we=1, reg_dst=0, alu_op=ADD.
- lw with mem_ready low for 2 cycles in MEM_RD -> mem_req held 3 cycles; WB_MEM on cycle 7 with mem_to_reg=1.
- beq with alu_zero=1, then again with alu_zero=0 -> pc_we=1/pc_src=1, then pc_we=0; 3 cycles each.
- jal 0x0C000010 -> in JUMP: pc_we=1, pc_src=2, reg_we=1, reg_dst=2, mem_to_reg=2.
- rst pulsed during MEM_WR -> mem_we=0 during reset; FETCH with mem_req=1 on the first post-reset cycle.
- Opcode 6'b111111 -> illegal=1 held until reset with MC_CTRL_ILLEGAL_EN; without it, back in FETCH after 2 cycles and no enables asserted.
